// File: rtl/store_buffer_if.sv
// store_buffer_if: execute/ROB/memory/load-port signals of the store buffer.
// master drives stores, commits, flushes, memory responses and loads; slave is the buffer.
interface store_buffer_if #(
  parameter int DEPTH_INDEX = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic                   enq_valid;
  logic [ADDR_W-1:0]      enq_addr;
  logic [DATA_W-1:0]      enq_data;
  logic [MASK_W-1:0]      enq_wmask;
  logic                   enq_ready;

  logic                   commit;
  logic                   flush;

  logic                   mem_req;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_data;
  logic [MASK_W-1:0]      mem_wmask;
  logic                   mem_resp;

  logic                   ld_valid;
  logic [ADDR_W-1:0]      ld_addr;
  logic                   ld_hit;
  logic [DATA_W-1:0]      ld_data;
  logic                   ld_stall;

  logic [DEPTH_INDEX:0]   count;
  logic                   empty;

  modport master (
    output enq_valid, enq_addr, enq_data, enq_wmask,
    output commit, flush, mem_resp, ld_valid, ld_addr,
    input  enq_ready, mem_req, mem_addr, mem_data, mem_wmask,
    input  ld_hit, ld_data, ld_stall, count, empty
  );

  modport slave (
    input  enq_valid, enq_addr, enq_data, enq_wmask,
    input  commit, flush, mem_resp, ld_valid, ld_addr,
    output enq_ready, mem_req, mem_addr, mem_data, mem_wmask,
    output ld_hit, ld_data, ld_stall, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO (head/commit/tail), drains committed stores, same-cycle load lookup.
// enq_ready drops only from registered fullness; drain holds until mem_resp. STORE_BUFFER_FWD_EN enables forwarding.
module store_buffer #(
  parameter int DEPTH_INDEX = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  sb
);
  localparam int DEPTH  = 2 ** DEPTH_INDEX;
  localparam int MASK_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(MASK_W);
  localparam int PTR_W  = DEPTH_INDEX + 1;

  typedef logic [PTR_W-1:0]       ptr_t;
  typedef logic [DEPTH_INDEX-1:0] idx_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] wmask;
  } entry_t;

  ptr_t   head_q, head_d;
  ptr_t   cmt_q, cmt_d;
  ptr_t   tail_q, tail_d;
  entry_t entries_q [DEPTH];
  entry_t entries_d [DEPTH];

  logic   full, empty_w, mem_req_w;
  logic   enq_fire, commit_fire, drain_fire;
  ptr_t   count_w;
  entry_t head_entry;

  assign count_w    = tail_q - head_q;
  assign empty_w    = (tail_q == head_q);
  assign full       = (tail_q[DEPTH_INDEX-1:0] == head_q[DEPTH_INDEX-1:0]) &&
                      (tail_q[DEPTH_INDEX] != head_q[DEPTH_INDEX]);
  assign mem_req_w  = (head_q != cmt_q);
  assign head_entry = entries_q[head_q[DEPTH_INDEX-1:0]];

  // Flush discards the incoming store, so it must not consume the slot either.
  assign enq_fire    = sb.enq_valid && !full && !sb.flush;
  assign commit_fire = sb.commit && (cmt_q != tail_q);
  assign drain_fire  = mem_req_w && sb.mem_resp;

  always_comb begin
    head_d = head_q + ptr_t'(drain_fire);
    cmt_d  = cmt_q + ptr_t'(commit_fire);
    // Commit is applied before flush so a retiring store survives the flush.
    tail_d = sb.flush ? cmt_d : (tail_q + ptr_t'(enq_fire));
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end
    if (enq_fire) begin
      entries_d[tail_q[DEPTH_INDEX-1:0]] = '{addr:  sb.enq_addr,
                                             data:  sb.enq_data,
                                             wmask: sb.enq_wmask};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  // Scan oldest to youngest from registered state; the last match is the youngest.
  logic              match_found;
  idx_t              scan_idx;
`ifdef STORE_BUFFER_FWD_EN
  logic [DATA_W-1:0] match_data;
  logic              match_full;
`endif

  always_comb begin
    match_found = 1'b0;
    scan_idx    = '0;
`ifdef STORE_BUFFER_FWD_EN
    match_data  = '0;
    match_full  = 1'b0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q[DEPTH_INDEX-1:0] + idx_t'(k);
      if ((ptr_t'(k) < count_w) &&
          ((entries_q[scan_idx].addr >> OFF_W) == (sb.ld_addr >> OFF_W))) begin
        match_found = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        match_data  = entries_q[scan_idx].data;
        match_full  = &entries_q[scan_idx].wmask;
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign sb.ld_hit   = sb.ld_valid && match_found && match_full;
  assign sb.ld_stall = sb.ld_valid && match_found && !match_full;
  assign sb.ld_data  = sb.ld_hit ? match_data : '0;
`else
  assign sb.ld_hit   = 1'b0;
  assign sb.ld_stall = sb.ld_valid && match_found;
  assign sb.ld_data  = '0;
`endif

  assign sb.enq_ready = !full;
  assign sb.mem_req   = mem_req_w;
  assign sb.mem_addr  = head_entry.addr;
  assign sb.mem_data  = head_entry.data;
  assign sb.mem_wmask = head_entry.wmask;
  assign sb.count     = count_w;
  assign sb.empty     = empty_w;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of store_buffer at DEPTH_INDEX=2; expectations follow STORE_BUFFER_FWD_EN.
module tb_store_buffer;
  localparam int DI = 2;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  store_buffer_if #(.DEPTH_INDEX(DI), .ADDR_W(AW), .DATA_W(DW)) sb_if ();

  store_buffer #(.DEPTH_INDEX(DI), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.enq_valid = 1'b0;
    sb_if.enq_addr  = '0;
    sb_if.enq_data  = '0;
    sb_if.enq_wmask = '0;
    sb_if.commit    = 1'b0;
    sb_if.flush     = 1'b0;
    sb_if.mem_resp  = 1'b0;
    sb_if.ld_valid  = 1'b0;
    sb_if.ld_addr   = '0;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    sb_if.enq_valid = 1'b1;
    sb_if.enq_addr  = a;
    sb_if.enq_data  = d;
    sb_if.enq_wmask = m;
    tick();
    sb_if.enq_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input string tag,
                      input logic h, input logic [31:0] d, input logic s);
    sb_if.ld_valid = 1'b1;
    sb_if.ld_addr  = a;
    #1;
    chk({tag, "_hit"},   sb_if.ld_hit,   h);
    chk({tag, "_data"},  sb_if.ld_data,  d);
    chk({tag, "_stall"}, sb_if.ld_stall, s);
    sb_if.ld_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_empty", sb_if.empty, 1'b1);
    chk("rst_count", sb_if.count, 3'd0);
    chk("rst_enq_ready", sb_if.enq_ready, 1'b1);
    chk("rst_mem_req", sb_if.mem_req, 1'b0);
    load(32'h0, "rst_ld", 1'b0, 32'h0, 1'b0);

    // Fill all four slots without committing; a fifth store is dropped.
    for (int i = 0; i < 4; i++) enq(32'h40 + 4 * i, 32'hA0 + i, 4'hF);
    #1;
    chk("full_count", sb_if.count, 3'd4);
    chk("full_enq_ready", sb_if.enq_ready, 1'b0);
    chk("full_mem_req", sb_if.mem_req, 1'b0);
    enq(32'h80, 32'hEE, 4'hF);
    #1;
    chk("fifth_count", sb_if.count, 3'd4);
    load(32'h80, "fifth_ld", 1'b0, 32'h0, 1'b0);
    load(32'h44, "full_ld", FWD, FWD ? 32'hA1 : 32'h0, !FWD);

    // Draining while full does not admit a same-cycle store.
    sb_if.commit = 1'b1;
    tick();
    sb_if.commit = 1'b0;
    #1;
    chk("c1_mem_req", sb_if.mem_req, 1'b1);
    chk("c1_mem_addr", sb_if.mem_addr, 32'h40);
    chk("c1_mem_data", sb_if.mem_data, 32'hA0);
    sb_if.enq_valid = 1'b1;
    sb_if.enq_addr  = 32'h80;
    sb_if.enq_data  = 32'hEE;
    sb_if.enq_wmask = 4'hF;
    sb_if.mem_resp  = 1'b1;
    tick();
    sb_if.enq_valid = 1'b0;
    sb_if.mem_resp  = 1'b0;
    #1;
    chk("drainfull_count", sb_if.count, 3'd3);
    chk("drainfull_enq_ready", sb_if.enq_ready, 1'b1);
    sb_if.commit = 1'b1;
    tick();
    tick();
    tick();
    sb_if.commit = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("fill_drain_req", sb_if.mem_req, 1'b1);
      chk("fill_drain_addr", sb_if.mem_addr, 32'h40 + 4 * i);
      chk("fill_drain_data", sb_if.mem_data, 32'hA0 + i);
      sb_if.mem_resp = 1'b1;
      tick();
      sb_if.mem_resp = 1'b0;
    end
    #1;
    chk("fill_drain_empty", sb_if.empty, 1'b1);
    chk("fill_drain_req_off", sb_if.mem_req, 1'b0);

    // Youngest match wins; partial masks stall.
    enq(32'h100, 32'h11111111, 4'hF);
    enq(32'h100, 32'h22222222, 4'hF);
    load(32'h102, "young", FWD, FWD ? 32'h22222222 : 32'h0, !FWD);
    enq(32'h200, 32'h33333333, 4'h3);
    load(32'h200, "partial", 1'b0, 32'h0, 1'b1);
    load(32'h300, "miss", 1'b0, 32'h0, 1'b0);
    enq(32'h200, 32'h44444444, 4'hF);
    load(32'h201, "over_partial", FWD, FWD ? 32'h44444444 : 32'h0, !FWD);
    do_reset();
    #1;
    chk("rst2_empty", sb_if.empty, 1'b1);
    chk("rst2_enq_ready", sb_if.enq_ready, 1'b1);
    load(32'h200, "rst2_ld", 1'b0, 32'h0, 1'b0);

    // A store enqueued this cycle is not visible to a same-cycle load.
    sb_if.ld_valid  = 1'b1;
    sb_if.ld_addr   = 32'h500;
    sb_if.enq_valid = 1'b1;
    sb_if.enq_addr  = 32'h500;
    sb_if.enq_data  = 32'h55;
    sb_if.enq_wmask = 4'h1;
    #1;
    chk("sameenq_stall", sb_if.ld_stall, 1'b0);
    tick();
    sb_if.enq_valid = 1'b0;
    #1;
    chk("nextcyc_stall", sb_if.ld_stall, 1'b1);
    sb_if.ld_valid = 1'b0;
    do_reset();

    // Commit plus flush in one cycle keeps the committed store; flush beats enqueue.
    enq(32'h600, 32'h1, 4'hF);
    enq(32'h604, 32'h2, 4'hF);
    enq(32'h608, 32'h3, 4'hF);
    sb_if.commit = 1'b1;
    tick();
    sb_if.flush     = 1'b1;
    sb_if.enq_valid = 1'b1;
    sb_if.enq_addr  = 32'h60C;
    sb_if.enq_data  = 32'h4;
    sb_if.enq_wmask = 4'hF;
    tick();
    sb_if.flush     = 1'b0;
    sb_if.enq_valid = 1'b0;
    sb_if.commit    = 1'b0;
    #1;
    chk("flush_count", sb_if.count, 3'd2);
    chk("flush_tail", dut.tail_q, 3'd2);
    chk("flush_cmt", dut.cmt_q, 3'd2);
    sb_if.commit = 1'b1;
    tick();
    sb_if.commit = 1'b0;
    #1;
    chk("idle_commit_cmt", dut.cmt_q, 3'd2);
    for (int i = 0; i < 2; i++) begin
      chk("flush_drain_req", sb_if.mem_req, 1'b1);
      chk("flush_drain_addr", sb_if.mem_addr, 32'h600 + 4 * i);
      chk("flush_drain_data", sb_if.mem_data, 32'h1 + i);
      sb_if.mem_resp = 1'b1;
      tick();
      sb_if.mem_resp = 1'b0;
      #1;
    end
    chk("flush_drain_empty", sb_if.empty, 1'b1);

    // Memory holds off for five cycles; request must stay stable.
    enq(32'h700, 32'h77, 4'hF);
    enq(32'h704, 32'h88, 4'hC);
    sb_if.commit = 1'b1;
    tick();
    tick();
    sb_if.commit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_req", sb_if.mem_req, 1'b1);
      chk("hold_addr", sb_if.mem_addr, 32'h700);
      tick();
    end
    chk("hold_count", sb_if.count, 3'd2);
    sb_if.mem_resp = 1'b1;
    tick();
    sb_if.mem_resp = 1'b0;
    #1;
    chk("resp_addr", sb_if.mem_addr, 32'h704);
    chk("resp_data", sb_if.mem_data, 32'h88);
    chk("resp_wmask", sb_if.mem_wmask, 4'hC);
    chk("resp_count", sb_if.count, 3'd1);
    sb_if.mem_resp = 1'b1;
    tick();
    tick();
    sb_if.mem_resp = 1'b0;
    #1;
    chk("stray_resp_count", sb_if.count, 3'd0);
    chk("stray_resp_empty", sb_if.empty, 1'b1);

    // Overlapped enqueue/commit/drain through the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      sb_if.enq_valid = 1'b1;
      sb_if.enq_addr  = 32'h800 + 4 * i;
      sb_if.enq_data  = 32'h1000 + i;
      sb_if.enq_wmask = 4'hF;
      sb_if.commit    = (i >= 1);
      sb_if.mem_resp  = (i >= 2);
      #1;
      if (i >= 2) begin
        chk("wrap_addr", sb_if.mem_addr, 32'h800 + 4 * (i - 2));
        chk("wrap_data", sb_if.mem_data, 32'h1000 + (i - 2));
      end
      tick();
    end
    sb_if.enq_valid = 1'b0;
    #1;
    chk("wrap_tail_addr8", sb_if.mem_addr, 32'h820);
    tick();
    sb_if.commit = 1'b0;
    #1;
    chk("wrap_tail_addr9", sb_if.mem_addr, 32'h824);
    tick();
    sb_if.mem_resp = 1'b0;
    #1;
    chk("wrap_empty", sb_if.empty, 1'b1);
    chk("wrap_count", sb_if.count, 3'd0);

    // Reset abandons a pending drain.
    enq(32'h900, 32'h99, 4'hF);
    sb_if.commit = 1'b1;
    tick();
    sb_if.commit = 1'b0;
    #1;
    chk("middrain_req", sb_if.mem_req, 1'b1);
    do_reset();
    #1;
    chk("middrain_empty", sb_if.empty, 1'b1);
    chk("middrain_req_off", sb_if.mem_req, 1'b0);
    chk("middrain_count", sb_if.count, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH_INDEX, default 3; log2 of entry count (DEPTH = 2**DEPTH_INDEX).
REQ-002 SHALL have parameter ADDR_W, default 32; byte address width.
REQ-003 SHALL have parameter DATA_W, default 32; data width, multiple of 8; MASK_W = DATA_W/8.
REQ-004 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports enq_valid in 1, enq_addr in ADDR_W, enq_data in DATA_W, enq_wmask in MASK_W; new store from execute.
REQ-007 SHALL have port enq_ready  out  1  slot available (= not full).
REQ-008 SHALL have port commit  in  1  ROB retired the oldest uncommitted store.
REQ-009 SHALL have port flush  in  1  discard all uncommitted entries.
REQ-010 SHALL have ports mem_req out 1, mem_addr out ADDR_W, mem_data out DATA_W, mem_wmask out MASK_W, mem_resp in 1; memory write handshake.
REQ-011 SHALL have ports ld_valid in 1, ld_addr in ADDR_W; load lookup.
REQ-012 SHALL have ports ld_hit out 1, ld_data out DATA_W, ld_stall out 1; lookup result.
REQ-013 SHALL have ports count out DEPTH_INDEX+1 (valid entries), empty out 1.

Function
REQ-014 SHALL keep head, commit and tail pointers of DEPTH_INDEX+1 bits (MSB = wrap bit); full when index bits equal and wrap bits differ; empty when equal.
REQ-015 SHALL write the entry at tail and advance tail when enq_valid && enq_ready; enq_valid while full SHALL be ignored with no state change.
REQ-016 SHALL derive enq_ready from registered state only; a drain in the same cycle SHALL NOT free a slot for an enqueue while full.
REQ-017 SHALL advance the commit pointer by one on commit when commit != tail; commit with no uncommitted entry SHALL be ignored.
REQ-018 SHALL set tail to the post-commit commit pointer on flush; a same-cycle commit SHALL be applied first and its entry survive; flush SHALL override a same-cycle enqueue.
REQ-019 SHALL assert mem_req combinationally while head != commit, presenting the head entry; outputs SHALL remain stable until mem_resp.
REQ-020 SHALL advance head on mem_req && mem_resp; mem_resp without mem_req SHALL be ignored.
REQ-021 SHALL, with ld_valid, compare ld_addr[ADDR_W-1:log2(MASK_W)] against all valid entries (head..tail-1, committed or not), combinationally, same cycle.
REQ-022 SHALL select the youngest matching entry; ld_hit=1 and ld_data=its data if its wmask is all ones; otherwise ld_stall=1.
REQ-023 SHALL assert ld_hit=0, ld_stall=0, ld_data=0 when ld_valid=0 or no entry matches; entries enqueued this cycle are not visible; an entry draining this cycle remains visible.
REQ-024 SHALL wrap all pointer arithmetic modulo 2**(DEPTH_INDEX+1) with no overflow flag.

Reset
REQ-025 SHALL on rst clear head, commit, tail to 0 and entry storage to 0; hence empty=1, count=0, enq_ready=1, mem_req=0, ld_hit=0, ld_stall=0.
REQ-026 SHALL give rst priority over every other input, including mid-handshake; a pending drain is abandoned.

Configuration
REQ-027 SHALL honour macro STORE_BUFFER_FWD_EN: defined -> forwarding per REQ-021..023.
REQ-028 SHALL, without STORE_BUFFER_FWD_EN, hold ld_hit=0 and ld_data=0 and assert ld_stall whenever ld_valid and any valid entry matches the word address, regardless of wmask.

Verification
REQ-029 SHALL cover (DEPTH_INDEX=2) four enqueues, no commit -> enq_ready=0, count=4; fifth enq_valid -> count stays 4, contents unchanged.
REQ-030 SHALL cover enqueue A@0x100 data 0x11111111 then B@0x100 data 0x22222222, both mask 0xF; load 0x102 -> ld_hit=1, ld_data=0x22222222.
REQ-031 SHALL cover youngest entry @0x200 mask 0x3 -> load 0x200 gives ld_stall=1, ld_hit=0.
REQ-032 SHALL cover 3 enqueues, 1 commit, then commit+flush same cycle -> count=2, tail=commit=2, drains 2 writes in order.
REQ-033 SHALL cover mem_resp held low 5 cycles -> mem_req/mem_addr stable; mem_resp high one cycle -> head+1, next entry presented.
REQ-034 SHALL cover wrap: 10 enqueue/commit/drain cycles through depth 4 -> FIFO order preserved, empty=1 at end; rst mid-drain -> empty=1 next cycle.
